exc_cp0_unit: RTL and testbench
===============================

// Module: exc_cp0_unit
// PURPOSE
//  Parametrised successor to the M-stage exception coder. Accepts per-instruction exception requests and N_INT
//  hardware interrupt lines, then prioritises them. Owns the CP0 state: SR, Cause, EPC, BadVAddr and PRId.
//  Issues the pipeline flush/redirect and handles mfc0/mtc0/eret. Sits beside the M stage; all writes land at the M->W edge.
// PARAMETERS
//  N_INT        6           number of hardware interrupt lines (1..6); IM/IP occupy bits [9+N_INT:10]
//  INT_EDGE     6'b000000   per-line mode: 1 = rising-edge sticky pending bit, 0 = level-sampled
//  HANDLER_PC   32'h4180    redirect target on exception
//  PRID         32'h0000_0000  read-only value of PRId (reg 15)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  m_valid      in   1      M stage holds a real instruction (0 = bubble)
//  m_pc         in   32     PC of M-stage instruction
//  m_bd         in   1      M-stage instruction sits in a branch delay slot
//  m_exc_valid  in   1      M stage raises a synchronous exception
//  m_exc_code   in   5      its ExcCode (4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov)
//  m_badvaddr   in   32     faulting address for codes 4/5
//  hw_int       in   N_INT  external interrupt lines
//  cp0_addr     in   5      mfc0/mtc0 register number
//  cp0_we       in   1      mtc0 write enable (M stage)
//  cp0_wdata    in   32     mtc0 data
//  eret         in   1      eret in M stage
//  cp0_rdata    out  32     mfc0 read data (combinational from current registers)
//  exc_flush    out  1      take exception now: flush F..M, redirect to HANDLER_PC
//  handler_pc   out  32     = HANDLER_PC
//  epc_out      out  32     current EPC, eret target
// BEHAVIOUR
//  - Reset: SR, Cause, EPC, BadVAddr, edge-pending, sync regs <= 0; exc_flush forced 0 while reset=1.
//  - Register map: 8 BadVAddr (RO), 12 SR {IM[9+N_INT:10], EXL[1], IE[0]}, 13 Cause {BD[31], IP[9+N_INT:10],
//    ExcCode[6:2]} (RO except edge IP bits), 14 EPC (RW), 15 PRId (RO). Unmapped reads return 0.
//    Writes to RO registers and to unused bits are ignored.
//  - IP generation: hw_int registered once (sync_q). Level lines: IP = sync_q. Edge lines: set on sync_q & ~prev_q.
//    An edge line clears only on an mtc0 to Cause writing 0 in that bit; set wins over clear in the same cycle.
//  - int_req = m_valid & IE & ~EXL & |(IP & IM). sync_req = m_valid & m_exc_valid.
//  - exc_flush = int_req | sync_req (same cycle, combinational). Priority: interrupt over synchronous.
//  - On exc_flush, at the next edge: ExcCode <= int_req ? 0 : m_exc_code.
//    If EXL was 0: EPC <= m_bd ? m_pc-4 : m_pc, BD <= m_bd. If EXL was 1: EPC/BD held.
//    EXL <= 1. BadVAddr <= m_badvaddr only for codes 4/5 and only when the synchronous exception won.
//  - The same-edge mtc0 and eret are discarded on exc_flush. The exception wins over both.
//  - eret & m_valid & ~exc_flush: EXL <= 0 at the next edge. epc_out is valid the same cycle.
//  - mtc0 with no exception: the register updates at the next edge. A same-cycle mfc0 returns the old value.
//  - Interrupts asserted while m_valid=0 stay pending (not dropped) until a valid instruction reaches M.
//  - Latency: hw_int -> earliest exc_flush is 2 cycles: 1 sync register + IP.
// TESTING
//  1 Reset, then mfc0 of 12/13/14/8 -> all 0. mfc0 15 -> PRID. mtc0 13 = 32'hFFFFFFFF -> Cause still 0.
//  2 SR=32'h0000_0401, pulse hw_int[0] (level) with m_pc=32'h3010 -> exc_flush 2 cycles later.
//    Then Cause.ExcCode=0, EPC=32'h3010, EXL=1.
//  3 m_exc_code=4, m_badvaddr=32'h7f1d, m_pc=32'h3020, m_bd=1 -> EPC=32'h301c, BD=1, BadVAddr=32'h7f1d.
//  4 Interrupt and Ov in the same cycle, with mtc0 EPC=32'h5000 -> ExcCode=0, EPC=m_pc, mtc0 discarded.
//  5 INT_EDGE[1]=1: 1-cycle pulse on hw_int[1] during a bubble run -> IP[11] stays set.
//    Exception is taken on the first m_valid. mtc0 Cause bit11=0 -> IP[11] clears.
//  6 EXL=1, Syscall at m_pc=32'h4190 -> exc_flush=1, ExcCode=8, EPC unchanged.
//    Then eret -> EXL=0 next cycle, epc_out = original EPC.

Source files
------------

// File: rtl/exc_cp0_unit.sv
// M-stage exception prioritiser and CP0 register file (SR, Cause, EPC, BadVAddr, PRId).
// exc_flush is combinational in the M cycle; hw_int reaches IP after two registers; no backpressure.
module exc_cp0_unit #(
  parameter int          N_INT      = 6,
  parameter logic [5:0]  INT_EDGE   = 6'b000000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic             m_bd,
  input  logic             m_exc_valid,
  input  logic [4:0]       m_exc_code,
  input  logic [31:0]      m_badvaddr,
  input  logic [N_INT-1:0] hw_int,
  input  logic [4:0]       cp0_addr,
  input  logic             cp0_we,
  input  logic [31:0]      cp0_wdata,
  input  logic             eret,
  output logic [31:0]      cp0_rdata,
  output logic             exc_flush,
  output logic [31:0]      handler_pc,
  output logic [31:0]      epc_out
);

  localparam int IP_LO = 10;
  localparam int IP_HI = 9 + N_INT;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  logic [N_INT-1:0] edge_mask;
  logic [N_INT-1:0] sync_q;
  logic [N_INT-1:0] prev_q;
  logic [N_INT-1:0] ip_q;
  logic [N_INT-1:0] im_q;
  logic [N_INT-1:0] ip_set;
  logic [N_INT-1:0] ip_clr;
  logic [N_INT-1:0] ip_next;

  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;

  logic int_req;
  logic sync_req;
  logic take;
  logic wr_en;
  logic eret_ok;
  logic bad_addr_code;

  assign edge_mask = INT_EDGE[N_INT-1:0];

  assign int_req  = m_valid & ie_q & ~exl_q & (|(ip_q & im_q));
  assign sync_req = m_valid & m_exc_valid;
  assign take     = int_req | sync_req;

  // A taken exception swallows the same-cycle mtc0 and eret.
  assign wr_en   = m_valid & cp0_we & ~take;
  assign eret_ok = m_valid & eret & ~take;

  assign bad_addr_code = (m_exc_code == 5'd4) || (m_exc_code == 5'd5);

  assign exc_flush  = take & ~reset;
  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc_q;

  // Edge lines latch a rising sync edge; a 0 written through Cause clears, but a new edge wins.
  assign ip_set = sync_q & ~prev_q & edge_mask;
  assign ip_clr = (wr_en && (cp0_addr == REG_CAUSE)) ? (~cp0_wdata[IP_HI:IP_LO] & edge_mask)
                                                      : '0;
  assign ip_next = (edge_mask & (ip_set | (ip_q & ~ip_clr))) | (~edge_mask & sync_q);

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_BADVADDR: cp0_rdata = badvaddr_q;
      REG_SR: begin
        cp0_rdata[IP_HI:IP_LO] = im_q;
        cp0_rdata[1]           = exl_q;
        cp0_rdata[0]           = ie_q;
      end
      REG_CAUSE: begin
        cp0_rdata[31]          = bd_q;
        cp0_rdata[IP_HI:IP_LO] = ip_q;
        cp0_rdata[6:2]         = exc_code_q;
      end
      REG_EPC:  cp0_rdata = epc_q;
      REG_PRID: cp0_rdata = PRID;
      default:  cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      ip_q       <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      sync_q <= hw_int;
      prev_q <= sync_q;
      ip_q   <= ip_next;
      if (take) begin
        exc_code_q <= int_req ? 5'd0 : m_exc_code;
        // Nested exceptions keep the outer EPC/BD so eret returns to the first fault.
        if (!exl_q) begin
          epc_q <= m_bd ? (m_pc - 32'd4) : m_pc;
          bd_q  <= m_bd;
        end
        exl_q <= 1'b1;
        if (!int_req && bad_addr_code) begin
          badvaddr_q <= m_badvaddr;
        end
      end else begin
        if (wr_en && (cp0_addr == REG_SR)) begin
          im_q  <= cp0_wdata[IP_HI:IP_LO];
          exl_q <= cp0_wdata[1];
          ie_q  <= cp0_wdata[0];
        end
        if (wr_en && (cp0_addr == REG_EPC)) begin
          epc_q <= cp0_wdata;
        end
        if (eret_ok) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_cp0_unit.sv
// Scoreboarded bench: directed scenarios then random traffic, checked against a cycle-level CP0 model.
module tb_exc_cp0_unit;

  localparam logic [5:0]  EDGE   = 6'b000010;
  localparam logic [31:0] HPC    = 32'h0000_4180;
  localparam logic [31:0] PRID_V = 32'h0001_8003;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_exc_valid;
  logic [4:0]  m_exc_code;
  logic [31:0] m_badvaddr;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  always #5 clk = ~clk;

  exc_cp0_unit #(
    .N_INT(6), .INT_EDGE(EDGE), .HANDLER_PC(HPC), .PRID(PRID_V)
  ) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc_valid(m_exc_valid), .m_exc_code(m_exc_code), .m_badvaddr(m_badvaddr),
    .hw_int(hw_int), .cp0_addr(cp0_addr), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
    .eret(eret), .cp0_rdata(cp0_rdata), .exc_flush(exc_flush),
    .handler_pc(handler_pc), .epc_out(epc_out)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic        bd;
    logic        ev;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [5:0]  hw;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic        er;
  } vec_t;

  typedef struct {
    logic        flush;
    logic [31:0] rdata;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Architectural state as a programmer sees it, plus the hw_int history seen through two flops.
  logic [5:0]  mim = '0, ep = '0, hist1 = '0, hist2 = '0;
  logic        mexl = 1'b0, mie = 1'b0, mbd = 1'b0;
  logic [4:0]  mcode = '0;
  logic [31:0] mepc = '0, mbad = '0;

  function automatic logic [31:0] mread(input logic [4:0] a, input logic [5:0] ip);
    case (a)
      5'd8:    return mbad;
      5'd12:   return {16'h0, mim, 8'h0, mexl, mie};
      5'd13:   return {mbd, 15'h0, ip, 3'b000, mcode, 2'b00};
      5'd14:   return mepc;
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t nop();
    vec_t s;
    s.rst = 1'b0; s.v = 1'b1; s.pc = 32'h0000_3000; s.bd = 1'b0;
    s.ev = 1'b0; s.code = 5'd0; s.bad = 32'h0; s.hw = 6'h0;
    s.addr = 5'd0; s.we = 1'b0; s.wd = 32'h0; s.er = 1'b0;
    return s;
  endfunction

  task automatic apply(input vec_t s, input bit chk);
    exp_t       e;
    logic [5:0] ip;
    logic [5:0] clr;
    logic       ireq;
    logic       sreq;
    logic       fl;
    @(posedge clk);
    #1;
    reset = s.rst; m_valid = s.v; m_pc = s.pc; m_bd = s.bd;
    m_exc_valid = s.ev; m_exc_code = s.code; m_badvaddr = s.bad; hw_int = s.hw;
    cp0_addr = s.addr; cp0_we = s.we; cp0_wdata = s.wd; eret = s.er;

    ip   = (ep & EDGE) | (hist2 & ~EDGE);
    ireq = s.v && mie && !mexl && ((ip & mim) != 6'h0);
    sreq = s.v && s.ev;
    fl   = (ireq || sreq) && !s.rst;
    e.flush = fl;
    e.rdata = mread(s.addr, ip);
    e.epc   = mepc;
    if (chk) exp_q.push_back(e);

    if (s.rst) begin
      mim = '0; ep = '0; hist1 = '0; hist2 = '0;
      mexl = 1'b0; mie = 1'b0; mbd = 1'b0; mcode = '0; mepc = '0; mbad = '0;
    end else begin
      clr = (s.v && s.we && !fl && s.addr == 5'd13) ? ~s.wd[15:10] : 6'h0;
      ep  = EDGE & ((hist1 & ~hist2) | (ep & ~clr));
      if (fl) begin
        mcode = ireq ? 5'd0 : s.code;
        if (!mexl) begin
          mepc = s.bd ? s.pc - 32'd4 : s.pc;
          mbd  = s.bd;
        end
        mexl = 1'b1;
        if (!ireq && (s.code == 5'd4 || s.code == 5'd5)) mbad = s.bad;
      end else begin
        if (s.v && s.we && s.addr == 5'd12) begin
          mim = s.wd[15:10]; mexl = s.wd[1]; mie = s.wd[0];
        end
        if (s.v && s.we && s.addr == 5'd14) mepc = s.wd;
        if (s.v && s.er) mexl = 1'b0;
      end
      hist2 = hist1;
      hist1 = s.hw;
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic v);
    vec_t s;
    s = nop(); s.addr = a; s.v = v;
    apply(s, 1'b1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    vec_t s;
    s = nop(); s.addr = a; s.we = 1'b1; s.wd = d;
    apply(s, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (exc_flush !== e.flush) begin
          miscompares++;
          $display("FAIL exc_flush t=%0t got %b want %b", $time, exc_flush, e.flush);
        end
        if (cp0_rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL cp0_rdata[%0d] t=%0t got %h want %h", cp0_addr, $time, cp0_rdata, e.rdata);
        end
        if (epc_out !== e.epc) begin
          miscompares++;
          $display("FAIL epc_out t=%0t got %h want %h", $time, epc_out, e.epc);
        end
        if (handler_pc !== HPC) begin
          miscompares++;
          $display("FAIL handler_pc t=%0t got %h want %h", $time, handler_pc, HPC);
        end
      end
    end
  end

  initial begin : stim
    vec_t s;
    logic [4:0] addrs [8];
    logic [4:0] codes [5];
    addrs = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3, 5'd31};
    codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    reset = 1'b1; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0; m_exc_valid = 1'b0;
    m_exc_code = '0; m_badvaddr = '0; hw_int = '0; cp0_addr = '0; cp0_we = 1'b0;
    cp0_wdata = '0; eret = 1'b0;

    // Reset: flush must stay low even with a live exception request.
    s = nop(); s.rst = 1'b1; s.ev = 1'b1; s.code = 5'd12;
    apply(s, 1'b0);
    apply(s, 1'b1);
    apply(s, 1'b1);

    rd(5'd12, 1'b1); rd(5'd13, 1'b1); rd(5'd14, 1'b1); rd(5'd8, 1'b1); rd(5'd15, 1'b1);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 1'b1);

    // Level interrupt on line 0.
    wr(5'd12, 32'h0000_0401);
    s = nop(); s.pc = 32'h0000_3010; s.hw = 6'h01; apply(s, 1'b1);
    s.hw = 6'h00;
    repeat (3) apply(s, 1'b1);
    rd(5'd13, 1'b1); rd(5'd14, 1'b1); rd(5'd12, 1'b1);

    // AdEL in a delay slot.
    wr(5'd12, 32'h0000_0401);
    s = nop(); s.pc = 32'h0000_3020; s.bd = 1'b1; s.ev = 1'b1; s.code = 5'd4;
    s.bad = 32'h0000_7f1d; s.addr = 5'd14;
    apply(s, 1'b1);
    rd(5'd14, 1'b1); rd(5'd13, 1'b1); rd(5'd8, 1'b1);

    // Interrupt and Ov together, with an mtc0 EPC that must be dropped.
    wr(5'd12, 32'h0000_0401);
    s = nop(); s.pc = 32'h0000_3030; s.hw = 6'h01;
    apply(s, 1'b1); apply(s, 1'b1);
    s.ev = 1'b1; s.code = 5'd12; s.we = 1'b1; s.addr = 5'd14; s.wd = 32'h0000_5000;
    apply(s, 1'b1);
    s = nop(); s.hw = 6'h00;
    apply(s, 1'b1);
    rd(5'd13, 1'b1); rd(5'd14, 1'b1); rd(5'd14, 1'b1);

    // Edge line 1 pulsed during bubbles stays pending until a real instruction.
    wr(5'd12, 32'h0000_0801);
    s = nop(); s.v = 1'b0; s.hw = 6'h02; s.addr = 5'd13;
    apply(s, 1'b1);
    s.hw = 6'h00;
    repeat (5) apply(s, 1'b1);
    s = nop(); s.pc = 32'h0000_3040; s.addr = 5'd13;
    apply(s, 1'b1);
    rd(5'd13, 1'b1);
    wr(5'd13, 32'h0000_0000);
    rd(5'd13, 1'b1);

    // Syscall while EXL=1, then eret.
    s = nop(); s.pc = 32'h0000_4190; s.ev = 1'b1; s.code = 5'd8; s.addr = 5'd14;
    apply(s, 1'b1);
    rd(5'd13, 1'b1);
    s = nop(); s.er = 1'b1; s.addr = 5'd12;
    apply(s, 1'b1);
    rd(5'd12, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      s.rst  = ($urandom_range(0, 399) == 0);
      s.v    = ($urandom_range(0, 3) != 0);
      s.pc   = $urandom & 32'hFFFF_FFFC;
      s.bd   = ($urandom_range(0, 3) == 0);
      s.ev   = ($urandom_range(0, 9) == 0);
      s.code = codes[$urandom_range(0, 4)];
      s.bad  = $urandom;
      s.hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
      s.addr = addrs[$urandom_range(0, 7)];
      s.we   = ($urandom_range(0, 3) == 0);
      s.wd   = $urandom;
      s.wd[1] = ($urandom_range(0, 3) == 0);
      s.wd[0] = ($urandom_range(0, 3) != 0);
      s.er   = ($urandom_range(0, 7) == 0);
      apply(s, 1'b1);
    end

    s = nop(); s.v = 1'b0;
    apply(s, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
